stack_addr_sequencer: RTL and testbench

Address and flow sequencer that sits directly upstream of `activation_stack`. During the forward pass it takes activation vectors from the forward datapath and writes them into the stack at ascending addresses 0..N-1. During the backward pass it issues read addresses N-2 down to 0, so the stack returns (addr, addr+1) activation pairs to the backprop stage one layer at a time.

---
 rtl/stack_addr_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_stack_addr_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_addr_sequencer.sv
// stack_addr_sequencer
// Address and flow sequencer in front of activation_stack.
// Forward pass: accepts N activation vectors and writes them to stack
// addresses 0..N-1. Backward pass: issues read addresses N-2 down to 0 so the
// stack returns (addr, addr+1) activation pairs to the backprop stage.
//
// Optional feature macro: STACK_SEQ_AUTOREAD_EN
//   defined   - backward reads advance on every output-address handshake,
//               with no wait for bwd_next.
//   undefined - each backward read is released by a bwd_next pulse.

module stack_addr_sequencer #(
    parameter int unsigned NEURON_NUM       = 6,
    parameter int unsigned ACTIVATION_WIDTH = 8,
    parameter int unsigned STACK_ADDR_WIDTH = 10,
    localparam int unsigned STACK_WIDTH     = NEURON_NUM * ACTIVATION_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [STACK_ADDR_WIDTH-1:0] layer_count,
    input  logic [STACK_WIDTH-1:0]      fwd_data,
    input  logic                        fwd_data_valid,
    output logic                        fwd_data_ready,
    output logic [STACK_WIDTH-1:0]      stack_input_data,
    output logic                        stack_input_data_valid,
    input  logic                        stack_input_data_ready,
    output logic [STACK_ADDR_WIDTH-1:0] stack_input_addr,
    output logic                        stack_input_addr_valid,
    input  logic                        stack_input_addr_ready,
    output logic [STACK_ADDR_WIDTH-1:0] stack_output_addr,
    output logic                        stack_output_addr_valid,
    input  logic                        stack_output_addr_ready,
    input  logic                        bwd_next,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WRITE      = 3'd1,
        S_READ_ISSUE = 3'd2,
        S_READ_WAIT  = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    state_t                      state_q;
    logic [STACK_ADDR_WIDTH-1:0] n_q;
    logic [STACK_ADDR_WIDTH-1:0] wr_ptr_q;
    logic [STACK_ADDR_WIDTH-1:0] rd_ptr_q;
    logic                        pending_q;
    logic                        fwd_ready_q;
    logic [STACK_WIDTH-1:0]      in_data_q;
    logic                        in_data_vld_q;
    logic [STACK_ADDR_WIDTH-1:0] in_addr_q;
    logic                        in_addr_vld_q;
    logic [STACK_ADDR_WIDTH-1:0] out_addr_q;
    logic                        out_addr_vld_q;
    logic                        busy_q;
    logic                        done_q;

    logic                        in_data_vld_d;
    logic                        in_addr_vld_d;
    logic                        fwd_hs_c;
    logic                        wr_complete_c;
    logic                        wr_last_c;
    logic                        rd_hs_c;
    logic                        rd_last_c;

    // Per-channel write completion and handshake decode.
    always_comb begin
        in_data_vld_d = in_data_vld_q && !stack_input_data_ready;
        in_addr_vld_d = in_addr_vld_q && !stack_input_addr_ready;
        fwd_hs_c      = fwd_data_valid && fwd_ready_q;
        wr_complete_c = pending_q && !in_data_vld_d && !in_addr_vld_d;
        wr_last_c     = (wr_ptr_q == (n_q - STACK_ADDR_WIDTH'(1)));
        rd_hs_c       = out_addr_vld_q && stack_output_addr_ready;
        rd_last_c     = (rd_ptr_q == '0);
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            n_q            <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            pending_q      <= 1'b0;
            fwd_ready_q    <= 1'b0;
            in_data_q      <= '0;
            in_data_vld_q  <= 1'b0;
            in_addr_q      <= '0;
            in_addr_vld_q  <= 1'b0;
            out_addr_q     <= '0;
            out_addr_vld_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && (layer_count >= STACK_ADDR_WIDTH'(2))) begin
                        n_q         <= layer_count;
                        wr_ptr_q    <= '0;
                        fwd_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    if (fwd_hs_c) begin
                        // Launch both stack channels for this vector.
                        in_data_q     <= fwd_data;
                        in_addr_q     <= wr_ptr_q;
                        in_data_vld_q <= 1'b1;
                        in_addr_vld_q <= 1'b1;
                        pending_q     <= 1'b1;
                        fwd_ready_q   <= 1'b0;
                    end else if (pending_q) begin
                        in_data_vld_q <= in_data_vld_d;
                        in_addr_vld_q <= in_addr_vld_d;
                        if (wr_complete_c) begin
                            pending_q <= 1'b0;
                            wr_ptr_q  <= wr_ptr_q + STACK_ADDR_WIDTH'(1);
                            if (wr_last_c) begin
                                // Last vector stored: first read is the pair (N-2, N-1).
                                rd_ptr_q       <= n_q - STACK_ADDR_WIDTH'(2);
                                out_addr_q     <= n_q - STACK_ADDR_WIDTH'(2);
                                out_addr_vld_q <= 1'b1;
                                state_q        <= S_READ_ISSUE;
                            end else begin
                                fwd_ready_q <= 1'b1;
                            end
                        end
                    end
                end

                S_READ_ISSUE: begin
`ifdef STACK_SEQ_AUTOREAD_EN
                    if (rd_hs_c) begin
                        if (rd_last_c) begin
                            out_addr_vld_q <= 1'b0;
                            done_q         <= 1'b1;
                            state_q        <= S_DONE;
                        end else begin
                            rd_ptr_q   <= rd_ptr_q - STACK_ADDR_WIDTH'(1);
                            out_addr_q <= rd_ptr_q - STACK_ADDR_WIDTH'(1);
                        end
                    end
`else
                    if (rd_hs_c) begin
                        out_addr_vld_q <= 1'b0;
                        state_q        <= S_READ_WAIT;
                    end
`endif
                end

                S_READ_WAIT: begin
                    if (bwd_next) begin
                        if (rd_last_c) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            rd_ptr_q       <= rd_ptr_q - STACK_ADDR_WIDTH'(1);
                            out_addr_q     <= rd_ptr_q - STACK_ADDR_WIDTH'(1);
                            out_addr_vld_q <= 1'b1;
                            state_q        <= S_READ_ISSUE;
                        end
                    end
                end

                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    busy_q         <= 1'b0;
                    fwd_ready_q    <= 1'b0;
                    in_data_vld_q  <= 1'b0;
                    in_addr_vld_q  <= 1'b0;
                    out_addr_vld_q <= 1'b0;
                    pending_q      <= 1'b0;
                    state_q        <= S_IDLE;
                end
            endcase
        end
    end

    assign fwd_data_ready          = fwd_ready_q;
    assign stack_input_data        = in_data_q;
    assign stack_input_data_valid  = in_data_vld_q;
    assign stack_input_addr        = in_addr_q;
    assign stack_input_addr_valid  = in_addr_vld_q;
    assign stack_output_addr       = out_addr_q;
    assign stack_output_addr_valid = out_addr_vld_q;
    assign busy                    = busy_q;
    assign done                    = done_q;

endmodule

// File: tb/tb_stack_addr_sequencer.sv
// Testbench for stack_addr_sequencer: cycle table, hand-written corner
// sequences and randomized passes against a transaction-level model.
module tb_stack_addr_sequencer;

    localparam int unsigned SAW = 10;
    localparam int unsigned SW  = 48;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [SAW-1:0] layer_count;
    logic [SW-1:0]  fwd_data;
    logic           fwd_data_valid;
    logic           fwd_data_ready;
    logic [SW-1:0]  stack_input_data;
    logic           stack_input_data_valid;
    logic           stack_input_data_ready;
    logic [SAW-1:0] stack_input_addr;
    logic           stack_input_addr_valid;
    logic           stack_input_addr_ready;
    logic [SAW-1:0] stack_output_addr;
    logic           stack_output_addr_valid;
    logic           stack_output_addr_ready;
    logic           bwd_next;
    logic           busy;
    logic           done;

    stack_addr_sequencer dut (
        .clk                     (clk),
        .rst                     (rst),
        .start                   (start),
        .layer_count             (layer_count),
        .fwd_data                (fwd_data),
        .fwd_data_valid          (fwd_data_valid),
        .fwd_data_ready          (fwd_data_ready),
        .stack_input_data        (stack_input_data),
        .stack_input_data_valid  (stack_input_data_valid),
        .stack_input_data_ready  (stack_input_data_ready),
        .stack_input_addr        (stack_input_addr),
        .stack_input_addr_valid  (stack_input_addr_valid),
        .stack_input_addr_ready  (stack_input_addr_ready),
        .stack_output_addr       (stack_output_addr),
        .stack_output_addr_valid (stack_output_addr_valid),
        .stack_output_addr_ready (stack_output_addr_ready),
        .bwd_next                (bwd_next),
        .busy                    (busy),
        .done                    (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    // Observed transactions
    logic [SW-1:0]  dq[$];
    logic [SAW-1:0] aq[$];
    logic [SAW-1:0] rq[$];
    int             fwd_hs_cnt = 0;
    int             done_cnt   = 0;
    logic [SW-1:0]  dat[16];

    // Previous-cycle channel state for hold checks
    logic           p_dv = 1'b0, p_drdy = 1'b0, p_av = 1'b0, p_ardy = 1'b0, p_ov = 1'b0, p_ordy = 1'b0;
    logic [SW-1:0]  p_d = '0;
    logic [SAW-1:0] p_a = '0, p_oa = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SW-1:0] rand48();
        return SW'({$urandom(), $urandom()});
    endfunction

    task automatic clear_q();
        dq.delete();
        aq.delete();
        rq.delete();
        fwd_hs_cnt = 0;
        done_cnt   = 0;
    endtask

    // Handshake monitor plus valid/payload hold checks under backpressure
    always @(posedge clk) begin
        if (rst) begin
            p_dv = 1'b0;
            p_av = 1'b0;
            p_ov = 1'b0;
        end else begin
            if (p_dv && !p_drdy)
                check("hold in_data", 64'({stack_input_data_valid, stack_input_data}), 64'({1'b1, p_d}));
            if (p_av && !p_ardy)
                check("hold in_addr", 64'({stack_input_addr_valid, stack_input_addr}), 64'({1'b1, p_a}));
            if (p_ov && !p_ordy)
                check("hold out_addr", 64'({stack_output_addr_valid, stack_output_addr}), 64'({1'b1, p_oa}));
            if (fwd_data_valid && fwd_data_ready) fwd_hs_cnt++;
            if (stack_input_data_valid && stack_input_data_ready) dq.push_back(stack_input_data);
            if (stack_input_addr_valid && stack_input_addr_ready) aq.push_back(stack_input_addr);
            if (stack_output_addr_valid && stack_output_addr_ready) rq.push_back(stack_output_addr);
            if (done) done_cnt++;
            p_dv = stack_input_data_valid;  p_drdy = stack_input_data_ready; p_d  = stack_input_data;
            p_av = stack_input_addr_valid;  p_ardy = stack_input_addr_ready; p_a  = stack_input_addr;
            p_ov = stack_output_addr_valid; p_ordy = stack_output_addr_ready; p_oa = stack_output_addr;
        end
    end

    task automatic check_zero(input string nm);
        check({nm, " fwd_ready"}, 64'(fwd_data_ready), 64'(0));
        check({nm, " in_dv"},     64'(stack_input_data_valid), 64'(0));
        check({nm, " in_av"},     64'(stack_input_addr_valid), 64'(0));
        check({nm, " in_data"},   64'(stack_input_data), 64'(0));
        check({nm, " in_addr"},   64'(stack_input_addr), 64'(0));
        check({nm, " out_v"},     64'(stack_output_addr_valid), 64'(0));
        check({nm, " out_addr"},  64'(stack_output_addr), 64'(0));
        check({nm, " busy"},      64'(busy), 64'(0));
        check({nm, " done"},      64'(done), 64'(0));
    endtask

    // Model: N writes to 0..N-1 carrying offered vectors in order, reads N-2..0, one done
    task automatic check_model(input int n, input string nm);
        check({nm, " n_wr_data"}, 64'(dq.size()), 64'(n));
        check({nm, " n_wr_addr"}, 64'(aq.size()), 64'(n));
        check({nm, " n_rd"},      64'(rq.size()), 64'(n - 1));
        for (int i = 0; i < n && i < dq.size(); i++)
            check($sformatf("%s wr_data[%0d]", nm, i), 64'(dq[i]), 64'(dat[i]));
        for (int i = 0; i < n && i < aq.size(); i++)
            check($sformatf("%s wr_addr[%0d]", nm, i), 64'(aq[i]), 64'(i));
        for (int i = 0; i < n - 1 && i < rq.size(); i++)
            check($sformatf("%s rd_addr[%0d]", nm, i), 64'(rq[i]), 64'(n - 2 - i));
        check({nm, " done_cnt"}, 64'(done_cnt), 64'(1));
    endtask

    task automatic idle_inputs();
        start = 0; layer_count = '0; fwd_data = '0; fwd_data_valid = 0; bwd_next = 0;
        stack_input_data_ready = 1; stack_input_addr_ready = 1; stack_output_addr_ready = 0;
    endtask

    task automatic run_pass(input int n, input bit rnd, input string nm);
        int k;
        int cyc;
        clear_q();
        for (int i = 0; i < n; i++) dat[i] = rand48();
        start = 1; layer_count = SAW'(n);
        tick();
        start = 0; layer_count = '0;
        check({nm, " busy"}, 64'(busy), 64'(1));
        cyc = 0;
        while (!done && cyc < 3000) begin
            k = fwd_hs_cnt;
            fwd_data_valid          = (k < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            fwd_data                = (k < n) ? dat[k] : rand48();
            stack_input_data_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stack_input_addr_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stack_output_addr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bwd_next                = rnd ? ($urandom_range(0, 3) == 0) : 1'b1;
            tick();
            cyc++;
        end
        check({nm, " done seen"}, 64'(done), 64'(1));
        idle_inputs();
        tick();
        check({nm, " busy after"}, 64'(busy), 64'(0));
        check({nm, " done after"}, 64'(done), 64'(0));
        check_model(n, nm);
    endtask

    typedef struct {
        bit      st;   int      n;    bit      fv;   longint  fd;   bit ordy; bit bwd;
        bit      e_fr; bit      e_iv; int      e_ia; longint  e_id;
        bit      e_ov; int      e_oa; bit      e_busy; bit    e_done;
    } vec_t;

    function automatic vec_t mkv(bit st, int n, bit fv, longint fd, bit ordy, bit bwd,
                                 bit e_fr, bit e_iv, int e_ia, longint e_id,
                                 bit e_ov, int e_oa, bit e_busy, bit e_done);
        vec_t v;
        v.st = st; v.n = n; v.fv = fv; v.fd = fd; v.ordy = ordy; v.bwd = bwd;
        v.e_fr = e_fr; v.e_iv = e_iv; v.e_ia = e_ia; v.e_id = e_id;
        v.e_ov = e_ov; v.e_oa = e_oa; v.e_busy = e_busy; v.e_done = e_done;
        return v;
    endfunction

    vec_t tbl[16];

    initial begin
        string nm;
        // Basic pass, N=4, all stack readies high; row = inputs before an edge, outputs after it
        tbl[0]  = mkv(1, 4, 0,   0, 0, 0,  1, 0, 0,   0, 0, 0, 1, 0);
        tbl[1]  = mkv(0, 0, 1, 100, 0, 0,  0, 1, 0, 100, 0, 0, 1, 0);
        tbl[2]  = mkv(0, 0, 1, 200, 0, 0,  1, 0, 0,   0, 0, 0, 1, 0);
        tbl[3]  = mkv(0, 0, 1, 200, 0, 0,  0, 1, 1, 200, 0, 0, 1, 0);
        tbl[4]  = mkv(0, 0, 1, 300, 0, 0,  1, 0, 0,   0, 0, 0, 1, 0);
        tbl[5]  = mkv(0, 0, 1, 300, 0, 0,  0, 1, 2, 300, 0, 0, 1, 0);
        tbl[6]  = mkv(0, 0, 1, 400, 0, 0,  1, 0, 0,   0, 0, 0, 1, 0);
        tbl[7]  = mkv(0, 0, 1, 400, 0, 0,  0, 1, 3, 400, 0, 0, 1, 0);
        tbl[8]  = mkv(0, 0, 0,   0, 0, 0,  0, 0, 0,   0, 1, 2, 1, 0);
        tbl[9]  = mkv(0, 0, 0,   0, 1, 0,  0, 0, 0,   0, 0, 0, 1, 0);
        tbl[10] = mkv(0, 0, 0,   0, 0, 1,  0, 0, 0,   0, 1, 1, 1, 0);
        tbl[11] = mkv(0, 0, 0,   0, 1, 0,  0, 0, 0,   0, 0, 0, 1, 0);
        tbl[12] = mkv(0, 0, 0,   0, 0, 1,  0, 0, 0,   0, 1, 0, 1, 0);
        tbl[13] = mkv(0, 0, 0,   0, 1, 0,  0, 0, 0,   0, 0, 0, 1, 0);
        tbl[14] = mkv(0, 0, 0,   0, 0, 1,  0, 0, 0,   0, 0, 0, 1, 1);
        tbl[15] = mkv(0, 0, 0,   0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0);

        rst = 1;
        idle_inputs();
        tick();
        tick();
        check_zero("reset");
        rst = 0;
        tick();
        check_zero("post_reset");

`ifndef STACK_SEQ_AUTOREAD_EN
        clear_q();
        for (int i = 0; i < 16; i++) begin
            start = tbl[i].st; layer_count = SAW'(tbl[i].n);
            fwd_data_valid = tbl[i].fv; fwd_data = SW'(tbl[i].fd);
            stack_output_addr_ready = tbl[i].ordy; bwd_next = tbl[i].bwd;
            tick();
            check($sformatf("row%0d fwd_ready", i), 64'(fwd_data_ready), 64'(tbl[i].e_fr));
            check($sformatf("row%0d in_valids", i),
                  64'({stack_input_data_valid, stack_input_addr_valid}), 64'({tbl[i].e_iv, tbl[i].e_iv}));
            if (tbl[i].e_iv) begin
                check($sformatf("row%0d in_addr", i), 64'(stack_input_addr), 64'(tbl[i].e_ia));
                check($sformatf("row%0d in_data", i), 64'(stack_input_data), 64'(tbl[i].e_id));
            end
            check($sformatf("row%0d out_v", i), 64'(stack_output_addr_valid), 64'(tbl[i].e_ov));
            if (tbl[i].e_ov)
                check($sformatf("row%0d out_addr", i), 64'(stack_output_addr), 64'(tbl[i].e_oa));
            check($sformatf("row%0d busy", i), 64'(busy), 64'(tbl[i].e_busy));
            check($sformatf("row%0d done", i), 64'(done), 64'(tbl[i].e_done));
        end
        idle_inputs();
        tick();
        check("table done_cnt", 64'(done_cnt), 64'(1));
`endif

        // Edge counts: N=1 and N=0 are ignored
        for (int n = 0; n < 2; n++) begin
            start = 1; layer_count = SAW'(n);
            tick();
            start = 0;
            check($sformatf("n%0d busy", n), 64'(busy), 64'(0));
            check($sformatf("n%0d fwd_ready", n), 64'(fwd_data_ready), 64'(0));
        end
        run_pass(2, 1'b0, "n2");

        // Split readiness followed by read backpressure, N=4
        clear_q();
        for (int i = 0; i < 4; i++) dat[i] = rand48();
        start = 1; layer_count = SAW'(4);
        tick();
        start = 0;
        check("split fwd_ready", 64'(fwd_data_ready), 64'(1));
        stack_input_addr_ready = 0;
        fwd_data_valid = 1; fwd_data = dat[0];
        tick();
        fwd_data_valid = 0;
        check("split launch", 64'({stack_input_data_valid, stack_input_addr_valid, fwd_data_ready}), 64'(3'b110));
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("split hold%0d", c),
                  64'({stack_input_data_valid, stack_input_addr_valid, fwd_data_ready}), 64'(3'b010));
            check($sformatf("split addr%0d", c), 64'(stack_input_addr), 64'(0));
        end
        stack_input_addr_ready = 1;
        tick();
        check("split release", 64'({stack_input_addr_valid, fwd_data_ready}), 64'(2'b01));
        for (int v = 1; v < 4; v++) begin
            fwd_data_valid = 1; fwd_data = dat[v];
            tick();
            fwd_data_valid = 0;
            check($sformatf("split wr_addr%0d", v), 64'(stack_input_addr), 64'(v));
            tick();
        end
        check("bp first read", 64'({stack_output_addr_valid, stack_output_addr}), 64'({1'b1, SAW'(2)}));
        stack_output_addr_ready = 0; bwd_next = 1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("bp hold%0d", c), 64'({stack_output_addr_valid, stack_output_addr}), 64'({1'b1, SAW'(2)}));
        end
        bwd_next = 0;
`ifdef STACK_SEQ_AUTOREAD_EN
        stack_output_addr_ready = 1;
        tick();
        check("auto rd1", 64'({stack_output_addr_valid, stack_output_addr}), 64'({1'b1, SAW'(1)}));
        tick();
        check("auto rd0", 64'({stack_output_addr_valid, stack_output_addr}), 64'({1'b1, SAW'(0)}));
        tick();
        check("auto done", 64'({stack_output_addr_valid, done}), 64'(2'b01));
        stack_output_addr_ready = 0;
        tick();
        check("auto idle", 64'(busy), 64'(0));
`else
        stack_output_addr_ready = 1;
        tick();
        stack_output_addr_ready = 0;
        check("bp wait", 64'(stack_output_addr_valid), 64'(0));
        for (int a = 1; a >= 0; a--) begin
            bwd_next = 1;
            tick();
            bwd_next = 0;
            check($sformatf("bp rd%0d", a), 64'({stack_output_addr_valid, stack_output_addr}), 64'({1'b1, SAW'(a)}));
            stack_output_addr_ready = 1;
            tick();
            stack_output_addr_ready = 0;
            check($sformatf("bp wait%0d", a), 64'(stack_output_addr_valid), 64'(0));
        end
        bwd_next = 1;
        tick();
        bwd_next = 0;
        check("bp done", 64'({done, busy}), 64'(2'b11));
        tick();
        check("bp idle", 64'({done, busy}), 64'(2'b00));
`endif
        tick();
        check_model(4, "split");

        // Mid-pass reset after two writes
        clear_q();
        idle_inputs();
        start = 1; layer_count = SAW'(4);
        tick();
        start = 0;
        for (int c = 0; c < 30 && aq.size() < 2; c++) begin
            fwd_data_valid = 1; fwd_data = rand48();
            tick();
        end
        check("midrst writes", 64'(aq.size()), 64'(2));
        fwd_data_valid = 0;
        rst = 1;
        tick();
        check_zero("midrst");
        rst = 0;
        repeat (3) tick();
        check("midrst no done", 64'(done_cnt), 64'(0));
        check("midrst busy", 64'(busy), 64'(0));
        run_pass(3, 1'b0, "after_rst");

        // Randomized passes
        for (int p = 0; p < 12; p++)
            run_pass(2 + $urandom_range(0, 5), 1'b1, $sformatf("rnd%0d", p));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
